// File: rtl/fetch_pc_unit_if.sv
// Fetch bus: instruction-memory req/ack plus decode valid/ready.
// master = fetch unit side, slave = memory/decode side.
interface fetch_pc_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output instr_valid,
    input  instr_ready,
    output instr,
    output instr_pc
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  instr_pc
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// PC owner and single-entry fetch buffer with branch redirect.
// Optional counters enabled by macro FETCH_STATS_EN.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  fetch_pc_unit_if.master        bus,
`ifdef FETCH_STATS_EN
  output logic [31:0]            fetch_count,
  output logic [31:0]            squash_count,
`endif
  output logic                   misalign_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        req_q, req_n;
  logic [31:0] addr_q, addr_n;
  logic        valid_q, valid_n;
  logic [31:0] instr_q, instr_n;
  logic [31:0] ipc_q, ipc_n;
  logic        err_q, err_n;
  logic        squash_q, squash_n;
  logic        drop;
  logic        xfer;
  logic        mis;

  assign mis = (redirect_pc[1:0] != 2'b00);

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = ipc_q;
  assign misalign_err    = err_q;

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_q    <= 1'b0;
      addr_q   <= 32'h0;
      valid_q  <= 1'b0;
      instr_q  <= 32'h0;
      ipc_q    <= 32'h0;
      err_q    <= 1'b0;
      squash_q <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      req_q    <= req_n;
      addr_q   <= addr_n;
      valid_q  <= valid_n;
      instr_q  <= instr_n;
      ipc_q    <= ipc_n;
      err_q    <= err_n;
      squash_q <= squash_n;
    end
  end

  // Next-state, redirect and handshake decisions
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    req_n    = req_q;
    addr_n   = addr_q;
    valid_n  = valid_q;
    instr_n  = instr_q;
    ipc_n    = ipc_q;
    err_n    = err_q;
    squash_n = squash_q;
    drop     = 1'b0;
    xfer     = 1'b0;

    unique case (state)
      IDLE: begin
        if (redirect_valid) begin
          pc_n = redirect_pc;
          if (mis) begin
            err_n   = 1'b1;
            state_n = HALT;
          end
        end else if (enable) begin
          state_n = REQ;
          req_n   = 1'b1;
          addr_n  = pc;
        end
      end

      REQ: begin
        if (redirect_valid) begin
          pc_n = redirect_pc;
          if (mis) err_n = 1'b1;
        end
        if (bus.imem_ack) begin
          req_n = 1'b0;
          if (redirect_valid || squash_q) begin
            squash_n = 1'b0;
            drop     = 1'b1;
            state_n  = err_n ? HALT : IDLE;
          end else begin
            instr_n = bus.imem_rdata;
            ipc_n   = addr_q;
            valid_n = 1'b1;
            pc_n    = pc + 32'd4;
            state_n = HOLD;
          end
        end else if (redirect_valid) begin
          squash_n = 1'b1;
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          // Redirect wins over a same-cycle accept
          pc_n    = redirect_pc;
          valid_n = 1'b0;
          drop    = 1'b1;
          if (mis) err_n = 1'b1;
          state_n = err_n ? HALT : IDLE;
        end else if (bus.instr_ready) begin
          valid_n = 1'b0;
          xfer    = 1'b1;
          if (enable) begin
            state_n = REQ;
            req_n   = 1'b1;
            addr_n  = pc;
          end else begin
            state_n = IDLE;
          end
        end
      end

      HALT: begin
        req_n   = 1'b0;
        valid_n = 1'b0;
      end

      default: state_n = IDLE;
    endcase
  end

`ifdef FETCH_STATS_EN
  // Accepted-transfer and discarded-fetch counters
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count  <= 32'h0;
      squash_count <= 32'h0;
    end else begin
      if (xfer) fetch_count <= fetch_count + 32'd1;
      if (drop) squash_count <= squash_count + 32'd1;
    end
  end
`else
  logic unused_stats;
  assign unused_stats = drop ^ xfer;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed table-driven bench for fetch_pc_unit.
// Each row: inputs for one cycle, expected registered outputs after it.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign_err;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count;
  logic [31:0] squash_count;
`endif

  fetch_pc_unit_if bus ();

  fetch_pc_unit #(.RESET_PC(32'h100)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus),
`ifdef FETCH_STATS_EN
    .fetch_count    (fetch_count),
    .squash_count   (squash_count),
`endif
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic        rv;
    logic [31:0] rpc;
    logic        ack;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_ipc;
    logic        e_err;
  } vec_t;

  localparam int N = 46;
  vec_t tbl [N];

  int tests = 0;
  int fails = 0;

  function automatic logic [31:0] word_of(logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic vec_t v(
    logic rst, logic en, logic rv, logic [31:0] rpc,
    logic ack, logic rdy,
    logic e_req, logic [31:0] e_addr,
    logic e_valid, logic [31:0] e_ipc, logic e_err
  );
    vec_t r;
    r.rst = rst; r.en = en; r.rv = rv; r.rpc = rpc;
    r.ack = ack; r.rdy = rdy;
    r.e_req = e_req; r.e_addr = e_addr;
    r.e_valid = e_valid; r.e_ipc = e_ipc; r.e_err = e_err;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic apply(vec_t r, int idx);
    string tag;
    @(negedge clk);
    reset          = r.rst;
    enable         = r.en;
    redirect_valid = r.rv;
    redirect_pc    = r.rpc;
    bus.imem_ack   = r.ack;
    bus.imem_rdata = word_of(r.e_ipc);
    bus.instr_ready = r.rdy;
    @(posedge clk);
    #1;
    tag = $sformatf("row%0d", idx);
    chk({tag, ".req"}, {31'h0, bus.imem_req}, {31'h0, r.e_req});
    chk({tag, ".valid"}, {31'h0, bus.instr_valid}, {31'h0, r.e_valid});
    chk({tag, ".err"}, {31'h0, misalign_err}, {31'h0, r.e_err});
    if (r.e_req) chk({tag, ".addr"}, bus.imem_addr, r.e_addr);
    if (r.e_valid) begin
      chk({tag, ".ipc"}, bus.instr_pc, r.e_ipc);
      chk({tag, ".instr"}, bus.instr, word_of(r.e_ipc));
    end
    if (r.rst) begin
      chk({tag, ".rst_addr"}, bus.imem_addr, 32'h0);
      chk({tag, ".rst_instr"}, bus.instr, 32'h0);
      chk({tag, ".rst_ipc"}, bus.instr_pc, 32'h0);
    end
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.instr_ready = 1'b0;

    // reset, then zero-wait streaming 100,104,108
    tbl[0]  = v(1,0,0,0,0,0, 0,0,0,0,0);
    tbl[1]  = v(1,1,0,0,0,0, 0,0,0,0,0);
    tbl[2]  = v(0,1,0,0,0,0, 1,32'h100,0,0,0);
    tbl[3]  = v(0,1,0,0,1,0, 0,0,1,32'h100,0);
    tbl[4]  = v(0,1,0,0,0,1, 1,32'h104,0,0,0);
    tbl[5]  = v(0,1,0,0,1,0, 0,0,1,32'h104,0);
    tbl[6]  = v(0,1,0,0,0,1, 1,32'h108,0,0,0);
    tbl[7]  = v(0,1,0,0,1,0, 0,0,1,32'h108,0);
    tbl[8]  = v(0,0,0,0,0,1, 0,0,0,0,0);
    // slow ack with redirect to 200 during the wait
    tbl[9]  = v(0,1,0,0,0,0, 1,32'h10C,0,0,0);
    tbl[10] = v(0,1,0,0,0,0, 1,32'h10C,0,0,0);
    tbl[11] = v(0,1,1,32'h200,0,0, 1,32'h10C,0,0,0);
    tbl[12] = v(0,1,0,0,0,0, 1,32'h10C,0,0,0);
    tbl[13] = v(0,1,0,0,1,0, 0,0,0,0,0);
    tbl[14] = v(0,1,0,0,0,0, 1,32'h200,0,0,0);
    tbl[15] = v(0,1,0,0,1,0, 0,0,1,32'h200,0);
    // decode stall, then redirect beats same-cycle ready
    tbl[16] = v(0,1,0,0,0,0, 0,0,1,32'h200,0);
    tbl[17] = v(0,1,0,0,0,0, 0,0,1,32'h200,0);
    tbl[18] = v(0,1,0,0,0,0, 0,0,1,32'h200,0);
    tbl[19] = v(0,1,0,0,0,0, 0,0,1,32'h200,0);
    tbl[20] = v(0,1,1,32'h40,0,1, 0,0,0,0,0);
    tbl[21] = v(0,1,0,0,0,0, 1,32'h40,0,0,0);
    tbl[22] = v(0,1,0,0,1,0, 0,0,1,32'h40,0);
    tbl[23] = v(0,1,0,0,0,1, 1,32'h44,0,0,0);
    tbl[24] = v(0,1,0,0,1,0, 0,0,1,32'h44,0);
    // misaligned redirect halts; later redirect ignored
    tbl[25] = v(0,1,1,32'h102,0,0, 0,0,0,0,1);
    tbl[26] = v(0,1,0,0,0,0, 0,0,0,0,1);
    tbl[27] = v(0,1,1,32'h0,0,0, 0,0,0,0,1);
    tbl[28] = v(0,1,0,0,0,1, 0,0,0,0,1);
    tbl[29] = v(1,1,0,0,0,0, 0,0,0,0,0);
    tbl[30] = v(0,1,0,0,0,0, 1,32'h100,0,0,0);
    // redirect to top of memory, PC wraps to 0
    tbl[31] = v(0,1,1,32'hFFFF_FFFC,0,0, 1,32'h100,0,0,0);
    tbl[32] = v(0,1,0,0,1,0, 0,0,0,0,0);
    tbl[33] = v(0,1,0,0,0,0, 1,32'hFFFF_FFFC,0,0,0);
    tbl[34] = v(0,1,0,0,1,0, 0,0,1,32'hFFFF_FFFC,0);
    tbl[35] = v(0,1,0,0,0,1, 1,32'h0,0,0,0);
    tbl[36] = v(0,1,0,0,1,0, 0,0,1,32'h0,0);
    tbl[37] = v(0,1,0,0,0,1, 1,32'h4,0,0,0);
    // enable drops mid-request: fetch completes, no new request
    tbl[38] = v(0,0,0,0,0,0, 1,32'h4,0,0,0);
    tbl[39] = v(0,0,0,0,1,0, 0,0,1,32'h4,0);
    tbl[40] = v(0,0,0,0,0,1, 0,0,0,0,0);
    tbl[41] = v(0,0,0,0,0,0, 0,0,0,0,0);
    tbl[42] = v(0,1,0,0,0,0, 1,32'h8,0,0,0);
    // reset mid-request, late ack ignored
    tbl[43] = v(1,1,0,0,0,0, 0,0,0,0,0);
    tbl[44] = v(0,0,0,0,1,0, 0,0,0,0,0);
    tbl[45] = v(0,0,0,0,0,0, 0,0,0,0,0);

    for (int i = 0; i < N; i++) begin
      apply(tbl[i], i);
`ifdef FETCH_STATS_EN
      if (i == 28) begin
        chk("fetch_count_mid", fetch_count, 32'd4);
        chk("squash_count_mid", squash_count, 32'd3);
      end
`endif
    end

    // ack and redirect in the same cycle drop the data
    apply(v(0,1,0,0,0,0, 1,32'h100,0,0,0), 100);
    apply(v(0,1,1,32'h300,1,0, 0,0,0,0,0), 101);
    apply(v(0,1,0,0,0,0, 1,32'h300,0,0,0), 102);
    // misaligned redirect while waiting: hold request, then halt
    apply(v(0,1,1,32'h302,0,0, 1,32'h300,0,0,1), 103);
    apply(v(0,1,0,0,1,0, 0,0,0,0,1), 104);
    apply(v(0,1,0,0,0,0, 0,0,0,0,1), 105);

`ifdef FETCH_STATS_EN
    chk("fetch_count_end", fetch_count, 32'd0);
    chk("squash_count_end", squash_count, 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
